sbox_ti_pipe: RTL

- Pipelined, multi-lane, 3-share threshold-implementation AES S-box with forward and inverse modes.
- Each lane runs the shared linear input map, the shared GF(2^8) inverter GF_INV_8_shared, and the shared linear output map.
- Valid/ready handshakes on both sides, plus an output FIFO so downstream back-pressure never stalls the free-running inverter pipeline.
- Sits between the masked state register and the masked ShiftRows/MixColumns datapath.

---
 rtl/sbox_ti_pipe.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sbox_ti_pipe.sv
// Pipelined multi-lane 3-share AES S-box (forward / inverse).
// Per lane: linear input map -> shared GF(2^8) inverter -> linear output map.
// An output FIFO with credit-based admission decouples downstream back-pressure
// from the free-running inverter pipeline.

// One byte lane of the shared datapath. Share index 0 is "share 1".
module sbox_ti_lane #(
  parameter int INV_LAT     = 4,
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic        clk,
  input  logic        ld_i,
  input  logic [7:0]  sh1_i,
  input  logic [7:0]  sh2_i,
  input  logic [7:0]  sh3_i,
  input  logic [15:0] rnd_i,
  input  logic        mode_s0_i,
  input  logic        mode_tl_i,
  output logic [7:0]  sh1_o,
  output logic [7:0]  sh2_o,
  output logic [7:0]  sh3_o
);
  typedef logic [2:0][7:0] sh_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Linear part of the AES affine map and of its inverse.
  function automatic logic [7:0] aff_lin(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4);
  endfunction

  function automatic logic [7:0] iaff_lin(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6);
  endfunction

  // Squaring is linear in GF(2^8), so it is applied share-wise.
  function automatic sh_t sh_sq(input sh_t a);
    sh_t r;
    for (int i = 0; i < 3; i++) r[i] = gf_mul(a[i], a[i]);
    return r;
  endfunction

  // Non-complete 3-share product: each output share omits one input share
  // index; the two mask bytes re-randomise the result (sum of masks is zero).
  function automatic sh_t sh_mul(input sh_t a, input sh_t b,
                                 input logic [7:0] m0, input logic [7:0] m1);
    sh_t z;
    z[0] = gf_mul(a[1], b[1]) ^ gf_mul(a[1], b[2]) ^ gf_mul(a[2], b[1]) ^ m0;
    z[1] = gf_mul(a[2], b[2]) ^ gf_mul(a[0], b[2]) ^ gf_mul(a[2], b[0]) ^ m1;
    z[2] = gf_mul(a[0], b[0]) ^ gf_mul(a[0], b[1]) ^ gf_mul(a[1], b[0]) ^ m0 ^ m1;
    return z;
  endfunction

  sh_t         s0_q, xin, x2;
  sh_t         p3_q, x2_1_q, p12_q, p15_q, x2_2_q, p252_q, x2_3_q, p254_q;
  sh_t         y, yo;
  logic [15:0] r0_q, r1_q, r2_q, r3_q;

  // Input map: identity forward; inverse-affine (constant on share 1) inverse.
  always_comb begin
    xin = s0_q;
    if (SUPPORT_INV && mode_s0_i) begin
      for (int i = 0; i < 3; i++) xin[i] = iaff_lin(s0_q[i]);
      xin[0] = xin[0] ^ 8'h05;
    end
  end

  assign x2 = sh_sq(xin);

  // Stage 0 capture, then x^254 as x^3, x^15, x^252, x^254 over four stages.
  always_ff @(posedge clk) begin
    if (ld_i) begin
      s0_q <= {sh3_i, sh2_i, sh1_i};
      r0_q <= rnd_i;
    end
    p3_q   <= sh_mul(x2, xin, r0_q[15:8], r0_q[7:0]);
    x2_1_q <= x2;
    r1_q   <= r0_q;
    p12_q  <= sh_sq(sh_sq(p3_q));
    p15_q  <= sh_mul(sh_sq(sh_sq(p3_q)), p3_q, r1_q[7:0], r1_q[15:8]);
    x2_2_q <= x2_1_q;
    r2_q   <= r1_q;
    p252_q <= sh_mul(sh_sq(sh_sq(sh_sq(sh_sq(p15_q)))), p12_q,
                     r2_q[15:8] ^ r2_q[7:0], r2_q[15:8]);
    x2_3_q <= x2_2_q;
    r3_q   <= r2_q;
    p254_q <= sh_mul(p252_q, x2_3_q, r3_q[7:0], r3_q[15:8] ^ r3_q[7:0]);
  end

  // Inverter core is four stages; any extra latency is plain delay.
  if (INV_LAT > 4) begin : g_pad
    sh_t pad_q [INV_LAT-4];
    // Delay line padding the inverter to INV_LAT stages.
    always_ff @(posedge clk) begin
      pad_q[0] <= p254_q;
      for (int i = 1; i < INV_LAT - 4; i++) pad_q[i] <= pad_q[i-1];
    end
    assign y = pad_q[INV_LAT-5];
  end else begin : g_nopad
    assign y = p254_q;
  end

  // Output map: affine (0x63 on share 1 only) forward; identity inverse.
  always_comb begin
    yo = y;
    if (!(SUPPORT_INV && mode_tl_i)) begin
      for (int i = 0; i < 3; i++) yo[i] = aff_lin(y[i]);
      yo[0] = yo[0] ^ 8'h63;
    end
  end

  assign sh1_o = yo[0];
  assign sh2_o = yo[1];
  assign sh3_o = yo[2];
endmodule

module sbox_ti_pipe #(
  parameter int NLANES      = 1,
  parameter int INV_LAT     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NLANES-1:0]  in_sh1,
  input  logic [8*NLANES-1:0]  in_sh2,
  input  logic [8*NLANES-1:0]  in_sh3,
  input  logic [16*NLANES-1:0] in_rnd,
  input  logic                 in_inv,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*NLANES-1:0]  out_sh1,
  output logic [8*NLANES-1:0]  out_sh2,
  output logic [8*NLANES-1:0]  out_sh3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [NLANES-1:0][7:0] s3;
    logic [NLANES-1:0][7:0] s2;
    logic [NLANES-1:0][7:0] s1;
  } ent_t;

  logic                   acc, pop, fifo_wr, mode_in;
  logic [INV_LAT:0]       vld_pipe_q, mode_q;
  logic [CW-1:0]          occ_q, occ_d, cnt_q, cnt_d;
  logic [PW-1:0]          wr_q, rd_q;
  logic [NLANES-1:0][7:0] tl1, tl2, tl3;
  ent_t                   mem_q [FIFO_DEPTH];
  ent_t                   head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (occ_q < CW'(FIFO_DEPTH)) & ~rst;
  assign acc       = in_valid & in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (occ_q != '0);
  assign fifo_wr   = vld_pipe_q[INV_LAT];
  assign mode_in   = in_inv & SUPPORT_INV;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    sbox_ti_lane #(.INV_LAT(INV_LAT), .SUPPORT_INV(SUPPORT_INV)) u_lane (
      .clk       (clk),
      .ld_i      (acc),
      .sh1_i     (in_sh1[8*k +: 8]),
      .sh2_i     (in_sh2[8*k +: 8]),
      .sh3_i     (in_sh3[8*k +: 8]),
      .rnd_i     (in_rnd[16*k +: 16]),
      .mode_s0_i (mode_q[0]),
      .mode_tl_i (mode_q[INV_LAT]),
      .sh1_o     (tl1[k]),
      .sh2_o     (tl2[k]),
      .sh3_o     (tl3[k])
    );
  end

  // Credit and FIFO fill counters: +1/-1, unchanged when both happen.
  always_comb begin
    occ_d = occ_q;
    case ({acc, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    cnt_d = cnt_q;
    case ({fifo_wr, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: valid/mode delay lines, credits, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      mode_q     <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[INV_LAT-1:0], acc};
      mode_q     <= {mode_q[INV_LAT-1:0], acc & mode_in};
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      if (fifo_wr) wr_q <= ptr_inc(wr_q);
      if (pop)     rd_q <= ptr_inc(rd_q);
    end
  end

  // FIFO storage; the write slot doubles as the registered output-map stage.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_q] <= '{s3: tl3, s2: tl2, s1: tl1};
  end

  // Head is gated so shares read zero whenever nothing is valid.
  assign head    = mem_q[rd_q];
  assign out_sh1 = out_valid ? head.s1 : '0;
  assign out_sh2 = out_valid ? head.s2 : '0;
  assign out_sh3 = out_valid ? head.s3 : '0;
endmodule
